pio_pulse_sequencer: RTL

//  Avalon-MM controller that drives a single-bit output PIO through that PIO's s1 slave port.

---
 rtl/pio_seq_pkg.sv | 25 ++
 rtl/pio_pulse_sequencer_timer.sv | 29 ++
 rtl/pio_pulse_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pio_seq_pkg.sv
// pio_seq_pkg: shared types and constants for the PIO pulse sequencer.
// Holds the FSM state encoding, register map and CTRL bit positions.
package pio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_HI,
    HOLD_HI,
    WR_LO,
    HOLD_LO
  } seq_state_e;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_HIGH = 2'd1;
  localparam logic [1:0] ADDR_LOW  = 2'd2;
  localparam logic [1:0] ADDR_CNT  = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_BUSY  = 0;
  localparam int unsigned CTRL_STOP  = 1;
  localparam int unsigned CTRL_CONT  = 2;
  localparam int unsigned CTRL_DONE  = 3;
  localparam int unsigned CTRL_IRQEN = 4;

endpackage

// File: rtl/pio_pulse_sequencer_timer.sv
// pio_seq_timer: loadable down-counter that stops at 1.
// expired_o is high while the count sits at 1.
module pio_seq_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expired_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q > ONE) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign expired_o = (cnt_q == ONE);

endmodule

// File: rtl/pio_pulse_sequencer.sv
// pio_pulse_sequencer: Avalon-MM pulse train generator that
// drives a single-bit PIO through one-cycle writes to its s1 port.
module pio_pulse_sequencer
  import pio_seq_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter logic [1:0]  PIO_ADDR = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  seq_state_e state_q, state_d;

  logic [CNT_W-1:0] high_q, low_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cont_q, irq_en_q;
  logic done_q, done_d;
  logic stop_q, stop_d;

  logic wr, ctrl_wr, cnt_wr;
  logic start_w, stop_w, clr_w, stop_req;
  logic busy, dec, done_set;
  logic tmr_load, tmr_exp;
  logic [CNT_W-1:0] tmr_val;

  assign wr       = chipselect & ~write_n;
  assign ctrl_wr  = wr && (address == ADDR_CTRL);
  assign cnt_wr   = wr && (address == ADDR_CNT);
  assign start_w  = ctrl_wr & writedata[CTRL_START];
  assign stop_w   = ctrl_wr & writedata[CTRL_STOP];
  assign clr_w    = ctrl_wr & writedata[CTRL_DONE];
  assign busy     = (state_q != IDLE);
  assign stop_req = stop_q | stop_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_q   <= '0;
      low_q    <= '0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (wr) begin
      unique case (1'b1)
        address == ADDR_CTRL: begin
          cont_q   <= writedata[CTRL_CONT];
          irq_en_q <= writedata[CTRL_IRQEN];
        end
        address == ADDR_HIGH: high_q <= writedata[CNT_W-1:0];
        address == ADDR_LOW:  low_q  <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
    end
  end

  // Phases of 0/1 cycles skip HOLD; longer ones load len-1
  // so the next strobe lands exactly len cycles later.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    dec      = 1'b0;
    done_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_w && !stop_w &&
            (cnt_q != '0 || writedata[CTRL_CONT]))
          state_d = WR_HI;
      end
      WR_HI: begin
        if (stop_req || high_q <= ONE) begin
          state_d = WR_LO;
        end else begin
          state_d  = HOLD_HI;
          tmr_load = 1'b1;
          tmr_val  = high_q - ONE;
        end
      end
      HOLD_HI: begin
        if (stop_req || tmr_exp)
          state_d = WR_LO;
      end
      WR_LO: begin
        if (stop_req) begin
          state_d = IDLE;
        end else begin
          dec = !cont_q && (cnt_q != '0);
          if (low_q > ONE) begin
            state_d  = HOLD_LO;
            tmr_load = 1'b1;
            tmr_val  = low_q - ONE;
          end else if (cont_q || cnt_q > ONE) begin
            state_d = WR_HI;
          end else begin
            state_d  = IDLE;
            done_set = 1'b1;
          end
        end
      end
      HOLD_LO: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (tmr_exp) begin
          if (cont_q || cnt_q != '0) begin
            state_d = WR_HI;
          end else begin
            state_d  = IDLE;
            done_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_wr && !busy)
      cnt_d = writedata[CNT_W-1:0];
    else if (dec)
      cnt_d = cnt_q - ONE;
  end

  assign stop_d = (state_d == IDLE) ? 1'b0
                : (stop_q | (stop_w & busy));
  assign done_d = done_set ? 1'b1
                : (clr_w ? 1'b0 : done_q);

  pio_seq_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmr_load),
    .val_i     (tmr_val),
    .expired_o (tmr_exp)
  );

  always_comb begin
    readdata = '0;
    if (chipselect && !read_n) begin
      unique case (address)
        ADDR_CTRL: begin
          readdata[CTRL_BUSY]  = busy;
          readdata[CTRL_CONT]  = cont_q;
          readdata[CTRL_DONE]  = done_q;
          readdata[CTRL_IRQEN] = irq_en_q;
        end
        ADDR_HIGH: readdata = 32'(high_q);
        ADDR_LOW:  readdata = 32'(low_q);
        ADDR_CNT:  readdata = 32'(cnt_q);
      endcase
    end
  end

  assign irq            = done_q & irq_en_q;
  assign pio_address    = PIO_ADDR;
  assign pio_chipselect = (state_q == WR_HI) || (state_q == WR_LO);
  assign pio_write_n    = ~pio_chipselect;
  assign pio_writedata  = {31'b0, state_q == WR_HI};

endmodule
